vram_wr_sched: RTL and testbench
================================

// Module: vram_wr_sched
// PURPOSE
//  Write-port scheduler for the character VRAM dual-port RAM. Shares the single
//  RAM write port between two host writers (H0, H1) and a built-in fill engine
//  (screen clear / region fill). Round-robin arbitration, one write per cycle.
//  Sits between the host/bus logic and the RAM's W_CK_i-side write port.
// PARAMETERS
//  C_DAT_W  8   data width, equal to the RAM's data width
//  C_ADR_W  10  address width, equal to the RAM's address width; depth 2**C_ADR_W
// PORTS
//  CK_i          in   1        single clock; also drives the RAM's W_CK_i
//  XAR_i         in   1        asynchronous reset, active low
//  H0_REQ_i      in   1        host0 write request; held until H0_ACK_o
//  H0_ADR_i      in   C_ADR_W  host0 address, stable while H0_REQ_i=1
//  H0_DAT_i      in   C_DAT_W  host0 data, stable while H0_REQ_i=1
//  H0_ACK_o      out  1        host0 grant; write accepted on this edge
//  H1_REQ_i/H1_ADR_i/H1_DAT_i/H1_ACK_o   same as H0, host1
//  FILL_START_i  in   1        1-cycle pulse: start fill; ignored if FILL_BUSY_o=1
//  FILL_ADR_i    in   C_ADR_W  fill start address, sampled with FILL_START_i
//  FILL_LEN_i    in   C_ADR_W+1 word count 0..2**C_ADR_W, sampled with start
//  FILL_DAT_i    in   C_DAT_W  fill pattern, sampled with start
//  FILL_BUSY_o   out  1        fill engine active
//  FILL_DONE_o   out  1        1-cycle pulse when fill completes
//  WE_o          out  1        RAM write enable (registered)
//  WAs_o         out  C_ADR_W  RAM write address (registered)
//  WDs_o         out  C_DAT_W  RAM write data (registered)
// BEHAVIOUR
//  - Reset (XAR_i=0): all outputs 0, FSM=IDLE, RR pointer=FILL (H0 first).
//  - Sources: H0 (REQ_i), H1 (REQ_i), FILL (FSM=RUN and remaining>0).
//  - RR: search order starts at source after last granted: H0->H1->FILL->H0.
//    At most one ACK/grant per cycle; pointer updates only on a grant.
//  - ACK_o combinational from REQ_i and pointer; ACK high = write accepted at
//    this edge. Host must drop REQ or present next word the cycle after ACK.
//  - Latency: grant at edge N -> WE_o=1 with that ADR/DAT during cycle N+1.
//    WE_o=0 in any cycle following no grant; WAs_o/WDs_o hold last value.
//  - Fill FSM: IDLE --START,LEN>0--> RUN; IDLE --START,LEN=0--> DONE (no write).
//    RUN: each FILL grant writes FILL_DAT at cur addr, addr+1 mod 2**C_ADR_W
//    (wraps 1023->0), remaining-1; last grant -> DONE. DONE -> IDLE next cycle,
//    FILL_DONE_o=1 only in DONE. FILL_BUSY_o=1 in RUN and DONE.
//  - LEN=2**C_ADR_W writes every location exactly once.
//  - START during RUN/DONE ignored; START same cycle as host REQ: fill is not
//    a requester until RUN (next cycle), so host is granted if pending.
//  - Guaranteed bandwidth: with all three requesting, each gets 1 of 3 cycles.
//  - Reset mid-fill: fill aborted, no DONE pulse, pending writes dropped.
// STRUCTURE
//  - Package vram_sched_pkg: source indices (SRC_H0/H1/FILL), FSM state
//    encoding (IDLE/RUN/DONE), width helpers.
//  - Sub-module rr_arb3: 3-way round-robin arbiter (req[2:0], grant one-hot,
//    pointer register). Top holds fill FSM, counters and output register.
// TESTING
//  1 reset: XAR_i low mid-traffic -> WE_o=0, ACKs 0, FILL_BUSY_o=0 at once.
//  2 H0 REQ ADR=0x010 DAT=0x41 alone -> H0_ACK same cycle, next cycle WE_o=1,
//    WAs_o=0x010, WDs_o=0x41.
//  3 H0,H1 both held 4 cycles -> ACK order H0,H1,H0,H1; no cycle double grant.
//  4 fill ADR=0x3FE LEN=4 DAT=0x20 -> writes 0x3FE,0x3FF,0x000,0x001; DONE
//    pulse 1 cycle after last grant; BUSY low the cycle after DONE.
//  5 fill LEN=10 with H0+H1 continuously requesting -> grants rotate
//    H0,H1,FILL; fill completes in 30 cycles; START during RUN ignored.
//  6 fill LEN=0 -> no WE_o, DONE pulse 1 cycle after START; LEN=1024 -> 1024
//    writes covering all addresses once.

Source files
------------

// File: rtl/vram_wr_sched_pkg.sv
// Shared definitions for the character VRAM write-port scheduler:
// source indices, fill FSM encoding and width helpers.
package vram_sched_pkg;

    localparam int C_DAT_W_DEF = 8;
    localparam int C_ADR_W_DEF = 10;

    // Source indices double as bit positions in the request/grant vectors.
    typedef enum logic [1:0] {
        SRC_H0   = 2'd0,
        SRC_H1   = 2'd1,
        SRC_FILL = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    // Fill length needs one extra bit so a full-memory fill is expressible.
    function automatic int len_w(input int adr_w);
        return adr_w + 1;
    endfunction

endpackage

// File: rtl/vram_wr_sched_if.sv
// Host, fill-control and RAM write-port signals of the scheduler.
// Hosts hold REQ/ADR/DAT until ACK; ACK high means the word is taken at this clock edge.
interface vram_wr_sched_if
    import vram_sched_pkg::*;
#(
    parameter int C_DAT_W = C_DAT_W_DEF,
    parameter int C_ADR_W = C_ADR_W_DEF
);
    logic                 H0_REQ_i;
    logic [C_ADR_W-1:0]   H0_ADR_i;
    logic [C_DAT_W-1:0]   H0_DAT_i;
    logic                 H0_ACK_o;
    logic                 H1_REQ_i;
    logic [C_ADR_W-1:0]   H1_ADR_i;
    logic [C_DAT_W-1:0]   H1_DAT_i;
    logic                 H1_ACK_o;
    logic                 FILL_START_i;
    logic [C_ADR_W-1:0]   FILL_ADR_i;
    logic [C_ADR_W:0]     FILL_LEN_i;
    logic [C_DAT_W-1:0]   FILL_DAT_i;
    logic                 FILL_BUSY_o;
    logic                 FILL_DONE_o;
    logic                 WE_o;
    logic [C_ADR_W-1:0]   WAs_o;
    logic [C_DAT_W-1:0]   WDs_o;
    fill_state_t          DBG_STATE_o;

    modport master (
        output H0_REQ_i, H0_ADR_i, H0_DAT_i, H1_REQ_i, H1_ADR_i, H1_DAT_i,
        output FILL_START_i, FILL_ADR_i, FILL_LEN_i, FILL_DAT_i,
        input  H0_ACK_o, H1_ACK_o, FILL_BUSY_o, FILL_DONE_o,
        input  WE_o, WAs_o, WDs_o, DBG_STATE_o
    );

    modport slave (
        input  H0_REQ_i, H0_ADR_i, H0_DAT_i, H1_REQ_i, H1_ADR_i, H1_DAT_i,
        input  FILL_START_i, FILL_ADR_i, FILL_LEN_i, FILL_DAT_i,
        output H0_ACK_o, H1_ACK_o, FILL_BUSY_o, FILL_DONE_o,
        output WE_o, WAs_o, WDs_o, DBG_STATE_o
    );

endinterface

// File: rtl/vram_wr_sched_rr_arb3.sv
// Three-way round-robin arbiter; search starts at the source after the last one granted.
module rr_arb3
    import vram_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] grant
);

    src_t ptr_q;
    src_t cand;

    always_comb begin
        grant = 3'b000;
        cand  = ptr_q;
        for (int i = 0; i < 3; i++) begin
            cand = (cand == SRC_FILL) ? SRC_H0 : src_t'(cand + 2'd1);
            if (grant == 3'b000 && req[cand]) begin
                grant[cand] = 1'b1;
            end
        end
    end

    // Pointer moves only when something was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SRC_FILL;
        end else if (grant[SRC_H0]) begin
            ptr_q <= SRC_H0;
        end else if (grant[SRC_H1]) begin
            ptr_q <= SRC_H1;
        end else if (grant[SRC_FILL]) begin
            ptr_q <= SRC_FILL;
        end
    end

endmodule

// File: rtl/vram_wr_sched.sv
// Write-port scheduler for the character VRAM: two host writers plus a fill engine
// share one registered RAM write port, one write per cycle, round-robin.
module vram_wr_sched
    import vram_sched_pkg::*;
#(
    parameter int C_DAT_W = C_DAT_W_DEF,
    parameter int C_ADR_W = C_ADR_W_DEF
)(
    input  logic             CK_i,
    input  logic             XAR_i,
    vram_wr_sched_if.slave   bus
);

    localparam int C_LEN_W = len_w(C_ADR_W);

    fill_state_t          state_q, state_d;
    logic [C_ADR_W-1:0]   fill_adr_q;
    logic [C_LEN_W-1:0]   fill_rem_q;
    logic [C_DAT_W-1:0]   fill_dat_q;
    logic [2:0]           req, grant;
    logic                 we_q;
    logic [C_ADR_W-1:0]   was_q;
    logic [C_DAT_W-1:0]   wds_q;

    // Requests are masked during reset so ACKs read 0 while XAR_i is low.
    assign req = XAR_i ? {(state_q == ST_RUN) && (fill_rem_q != '0),
                          bus.H1_REQ_i, bus.H0_REQ_i} : 3'b000;

    rr_arb3 u_arb (
        .clk   (CK_i),
        .rst_n (XAR_i),
        .req   (req),
        .grant (grant)
    );

    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.FILL_START_i) begin
                    state_d = (bus.FILL_LEN_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (grant[SRC_FILL] && fill_rem_q == C_LEN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Fill parameters are captured only from IDLE; address wraps naturally.
    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            fill_adr_q <= '0;
            fill_rem_q <= '0;
            fill_dat_q <= '0;
        end else if (state_q == ST_IDLE && bus.FILL_START_i) begin
            fill_adr_q <= bus.FILL_ADR_i;
            fill_rem_q <= bus.FILL_LEN_i;
            fill_dat_q <= bus.FILL_DAT_i;
        end else if (grant[SRC_FILL]) begin
            fill_adr_q <= fill_adr_q + 1'b1;
            fill_rem_q <= fill_rem_q - 1'b1;
        end
    end

    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            we_q  <= 1'b0;
            was_q <= '0;
            wds_q <= '0;
        end else begin
            we_q <= |grant;
            if (grant[SRC_H0]) begin
                was_q <= bus.H0_ADR_i;
                wds_q <= bus.H0_DAT_i;
            end else if (grant[SRC_H1]) begin
                was_q <= bus.H1_ADR_i;
                wds_q <= bus.H1_DAT_i;
            end else if (grant[SRC_FILL]) begin
                was_q <= fill_adr_q;
                wds_q <= fill_dat_q;
            end
        end
    end

    assign bus.H0_ACK_o    = grant[SRC_H0];
    assign bus.H1_ACK_o    = grant[SRC_H1];
    assign bus.FILL_BUSY_o = (state_q != ST_IDLE);
    assign bus.FILL_DONE_o = (state_q == ST_DONE);
    assign bus.WE_o        = we_q;
    assign bus.WAs_o       = was_q;
    assign bus.WDs_o       = wds_q;
    assign bus.DBG_STATE_o = state_q;

endmodule

// File: tb/tb_vram_wr_sched.sv
// Directed bench for vram_wr_sched: reset, single host write, host alternation,
// wrapping fill, fill under host load, zero-length and full-memory fills.
module tb_vram_wr_sched;
    import vram_sched_pkg::*;

    localparam int DW = 8;
    localparam int AW = 10;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [AW-1:0] exp_q[$];

    vram_wr_sched_if #(.C_DAT_W(DW), .C_ADR_W(AW)) bus ();

    vram_wr_sched #(.C_DAT_W(DW), .C_ADR_W(AW)) dut (
        .CK_i  (clk),
        .XAR_i (rst_n),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.H0_REQ_i     = 1'b0;
        bus.H0_ADR_i     = '0;
        bus.H0_DAT_i     = '0;
        bus.H1_REQ_i     = 1'b0;
        bus.H1_ADR_i     = '0;
        bus.H1_DAT_i     = '0;
        bus.FILL_START_i = 1'b0;
        bus.FILL_ADR_i   = '0;
        bus.FILL_LEN_i   = '0;
        bus.FILL_DAT_i   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic start_fill(input logic [AW-1:0] adr, input logic [AW:0] len,
                              input logic [DW-1:0] dat);
        bus.FILL_START_i = 1'b1;
        bus.FILL_ADR_i   = adr;
        bus.FILL_LEN_i   = len;
        bus.FILL_DAT_i   = dat;
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.WE_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b exp 0", bus.WE_o); end
        checks++; if (bus.WAs_o !== '0) begin errors++; $display("FAIL rst_was: got %0h exp 0", bus.WAs_o); end
        checks++; if (bus.WDs_o !== '0) begin errors++; $display("FAIL rst_wds: got %0h exp 0", bus.WDs_o); end
        checks++; if (bus.FILL_BUSY_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", bus.FILL_BUSY_o); end
        checks++; if (bus.FILL_DONE_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b exp 0", bus.FILL_DONE_o); end
        checks++; if (bus.DBG_STATE_o !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", bus.DBG_STATE_o, ST_IDLE); end

        // Traffic: H0 plus an 8-word fill, then reset mid-cycle.
        tick();
        bus.H0_REQ_i = 1'b1;
        bus.H0_ADR_i = 10'h0AA;
        bus.H0_DAT_i = 8'h5A;
        start_fill(10'h000, 11'd8, 8'h33);
        tick();
        bus.FILL_START_i = 1'b0;
        tick();
        checks++; if (bus.WE_o !== 1'b1) begin errors++; $display("FAIL pre_rst_we: got %0b exp 1", bus.WE_o); end
        checks++; if (bus.FILL_BUSY_o !== 1'b1) begin errors++; $display("FAIL pre_rst_busy: got %0b exp 1", bus.FILL_BUSY_o); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.WE_o !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %0b exp 0", bus.WE_o); end
        checks++; if (bus.H0_ACK_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ack0: got %0b exp 0", bus.H0_ACK_o); end
        checks++; if (bus.H1_ACK_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ack1: got %0b exp 0", bus.H1_ACK_o); end
        checks++; if (bus.FILL_BUSY_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b exp 0", bus.FILL_BUSY_o); end
        bus.H0_REQ_i = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (bus.FILL_DONE_o !== 1'b0 || bus.FILL_BUSY_o !== 1'b0 || bus.WE_o !== 1'b0) begin
                errors++;
                $display("FAIL post_rst_quiet c=%0d: done=%0b busy=%0b we=%0b exp all 0",
                         c, bus.FILL_DONE_o, bus.FILL_BUSY_o, bus.WE_o);
            end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        bus.H0_REQ_i = 1'b1;
        bus.H0_ADR_i = 10'h010;
        bus.H0_DAT_i = 8'h41;
        @(negedge clk);
        checks++; if (bus.H0_ACK_o !== 1'b1) begin errors++; $display("FAIL single_ack0: got %0b exp 1", bus.H0_ACK_o); end
        checks++; if (bus.H1_ACK_o !== 1'b0) begin errors++; $display("FAIL single_ack1: got %0b exp 0", bus.H1_ACK_o); end
        checks++; if (bus.WE_o !== 1'b0) begin errors++; $display("FAIL single_we_early: got %0b exp 0", bus.WE_o); end
        tick();
        bus.H0_REQ_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.WE_o !== 1'b1) begin errors++; $display("FAIL single_we: got %0b exp 1", bus.WE_o); end
        checks++; if (bus.WAs_o !== 10'h010) begin errors++; $display("FAIL single_was: got %0h exp 010", bus.WAs_o); end
        checks++; if (bus.WDs_o !== 8'h41) begin errors++; $display("FAIL single_wds: got %0h exp 41", bus.WDs_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.WE_o !== 1'b0) begin errors++; $display("FAIL single_we_off: got %0b exp 0", bus.WE_o); end
        checks++; if (bus.WAs_o !== 10'h010 || bus.WDs_o !== 8'h41) begin
            errors++; $display("FAIL single_hold: got %0h/%0h exp 010/41", bus.WAs_o, bus.WDs_o);
        end
    endtask

    task automatic test_two_hosts();
        logic exp0;
        do_reset();
        bus.H0_REQ_i = 1'b1; bus.H0_ADR_i = 10'h100; bus.H0_DAT_i = 8'hA0;
        bus.H1_REQ_i = 1'b1; bus.H1_ADR_i = 10'h200; bus.H1_DAT_i = 8'hB0;
        for (int c = 0; c < 4; c++) begin
            exp0 = (c % 2 == 0);
            @(negedge clk);
            checks++; if (bus.H0_ACK_o !== exp0 || bus.H1_ACK_o !== !exp0) begin
                errors++;
                $display("FAIL two_hosts_order c=%0d: got ack0=%0b ack1=%0b exp ack0=%0b ack1=%0b",
                         c, bus.H0_ACK_o, bus.H1_ACK_o, exp0, !exp0);
            end
            if (c > 0) begin
                checks++; if (bus.WAs_o !== (exp0 ? 10'h200 : 10'h100)) begin
                    errors++; $display("FAIL two_hosts_was c=%0d: got %0h exp %0h", c, bus.WAs_o, exp0 ? 10'h200 : 10'h100);
                end
            end
            tick();
        end
        bus.H0_REQ_i = 1'b0;
        bus.H1_REQ_i = 1'b0;
    endtask

    task automatic test_fill_wrap();
        logic [AW-1:0] exp_adr;
        do_reset();
        exp_q.delete();
        exp_q.push_back(10'h3FE); exp_q.push_back(10'h3FF);
        exp_q.push_back(10'h000); exp_q.push_back(10'h001);
        start_fill(10'h3FE, 11'd4, 8'h20);
        tick();
        bus.FILL_START_i = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++; if (bus.WE_o !== (c >= 1 && c <= 4)) begin
                errors++; $display("FAIL wrap_we c=%0d: got %0b exp %0b", c, bus.WE_o, (c >= 1 && c <= 4));
            end
            if (bus.WE_o === 1'b1 && exp_q.size() > 0) begin
                exp_adr = exp_q.pop_front();
                checks++; if (bus.WAs_o !== exp_adr || bus.WDs_o !== 8'h20) begin
                    errors++; $display("FAIL wrap_data c=%0d: got %0h/%0h exp %0h/20", c, bus.WAs_o, bus.WDs_o, exp_adr);
                end
            end
            checks++; if (bus.FILL_DONE_o !== (c == 4)) begin
                errors++; $display("FAIL wrap_done c=%0d: got %0b exp %0b", c, bus.FILL_DONE_o, (c == 4));
            end
            checks++; if (bus.FILL_BUSY_o !== (c <= 4)) begin
                errors++; $display("FAIL wrap_busy c=%0d: got %0b exp %0b", c, bus.FILL_BUSY_o, (c <= 4));
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_count: got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_fill_with_hosts();
        int  fill_cnt;
        int  win;
        logic e0, e1;
        do_reset();
        fill_cnt = 0;
        bus.H0_REQ_i = 1'b1; bus.H0_ADR_i = 10'h050; bus.H0_DAT_i = 8'h11;
        bus.H1_REQ_i = 1'b1; bus.H1_ADR_i = 10'h060; bus.H1_DAT_i = 8'h22;
        start_fill(10'h100, 11'd10, 8'h77);
        for (int c = 0; c < 34; c++) begin
            win = (c < 30) ? (c % 3) : (c % 2);
            e0 = (win == 0);
            e1 = (win == 1);
            @(negedge clk);
            checks++; if (bus.H0_ACK_o !== e0 || bus.H1_ACK_o !== e1) begin
                errors++;
                $display("FAIL load_rr c=%0d: got ack0=%0b ack1=%0b exp ack0=%0b ack1=%0b",
                         c, bus.H0_ACK_o, bus.H1_ACK_o, e0, e1);
            end
            if (bus.WE_o === 1'b1 && bus.WDs_o === 8'h77) begin
                checks++; if (bus.WAs_o !== 10'h100 + 10'(fill_cnt)) begin
                    errors++; $display("FAIL load_fill_adr: got %0h exp %0h", bus.WAs_o, 10'h100 + 10'(fill_cnt));
                end
                fill_cnt++;
            end
            checks++; if (bus.WDs_o === 8'hEE) begin errors++; $display("FAIL load_restart: got data ee exp no restart"); end
            checks++; if (bus.FILL_DONE_o !== (c == 30)) begin
                errors++; $display("FAIL load_done c=%0d: got %0b exp %0b", c, bus.FILL_DONE_o, (c == 30));
            end
            checks++; if (bus.FILL_BUSY_o !== (c >= 1 && c <= 30)) begin
                errors++; $display("FAIL load_busy c=%0d: got %0b exp %0b", c, bus.FILL_BUSY_o, (c >= 1 && c <= 30));
            end
            tick();
            bus.FILL_START_i = 1'b0;
            if (c == 4) start_fill(10'h300, 11'd3, 8'hEE);
        end
        checks++; if (fill_cnt != 10) begin errors++; $display("FAIL load_fill_count: got %0d exp 10", fill_cnt); end
        bus.H0_REQ_i = 1'b0;
        bus.H1_REQ_i = 1'b0;
    endtask

    task automatic test_fill_len0();
        do_reset();
        start_fill(10'h123, 11'd0, 8'h99);
        @(negedge clk);
        checks++; if (bus.FILL_BUSY_o !== 1'b0) begin errors++; $display("FAIL len0_busy_start: got %0b exp 0", bus.FILL_BUSY_o); end
        tick();
        bus.FILL_START_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.FILL_DONE_o !== 1'b1) begin errors++; $display("FAIL len0_done: got %0b exp 1", bus.FILL_DONE_o); end
        checks++; if (bus.FILL_BUSY_o !== 1'b1) begin errors++; $display("FAIL len0_busy: got %0b exp 1", bus.FILL_BUSY_o); end
        checks++; if (bus.WE_o !== 1'b0) begin errors++; $display("FAIL len0_we: got %0b exp 0", bus.WE_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.FILL_DONE_o !== 1'b0 || bus.FILL_BUSY_o !== 1'b0 || bus.WE_o !== 1'b0) begin
            errors++; $display("FAIL len0_after: done=%0b busy=%0b we=%0b exp all 0", bus.FILL_DONE_o, bus.FILL_BUSY_o, bus.WE_o);
        end
    endtask

    task automatic test_fill_full();
        logic seen [1024];
        int   writes, dups, bad, done_at, c;
        do_reset();
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        writes = 0; dups = 0; bad = 0; done_at = -1;
        start_fill(10'h200, 11'd1024, 8'h3C);
        tick();
        bus.FILL_START_i = 1'b0;
        c = 1;
        while (done_at < 0 && c < 1100) begin
            @(negedge clk);
            if (c == 2) begin
                checks++; if (bus.DBG_STATE_o !== ST_RUN) begin errors++; $display("FAIL full_state: got %0d exp %0d", bus.DBG_STATE_o, ST_RUN); end
            end
            if (bus.WE_o === 1'b1) begin
                writes++;
                if (bus.WDs_o !== 8'h3C) bad++;
                if (seen[bus.WAs_o]) dups++;
                seen[bus.WAs_o] = 1'b1;
            end
            if (bus.FILL_DONE_o === 1'b1) done_at = c;
            tick();
            c++;
        end
        checks++; if (done_at != 1025) begin errors++; $display("FAIL full_done_cycle: got %0d exp 1025", done_at); end
        checks++; if (writes != 1024) begin errors++; $display("FAIL full_writes: got %0d exp 1024", writes); end
        checks++; if (dups != 0) begin errors++; $display("FAIL full_dups: got %0d exp 0", dups); end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_data: got %0d bad exp 0", bad); end
        @(negedge clk);
        checks++; if (bus.FILL_BUSY_o !== 1'b0 || bus.WE_o !== 1'b0) begin
            errors++; $display("FAIL full_idle: busy=%0b we=%0b exp 0/0", bus.FILL_BUSY_o, bus.WE_o);
        end
    endtask

    // Sequence and final report
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_two_hosts();
        test_fill_wrap();
        test_fill_with_hosts();
        test_fill_len0();
        test_fill_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
